// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared encodings and the pipeline stage record for the
// hazard scoreboard.
//   CLS_*       instruction class carried in d_cls and in each stage record
//   FWD_*       E-stage operand select driven on fwd_a / fwd_b
//   stage_rec_t {valid, rd, we, cls} tracked for each pipeline stage
//   fwd_sel()   newest-first bypass priority for one source operand
package hazard_pkg;

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_LOAD   = 2'd1;
  localparam logic [1:0] CLS_MULDIV = 2'd2;
  localparam logic [1:0] CLS_OTHER  = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;  // read the register file
  localparam logic [1:0] FWD_M  = 2'd1;  // M-stage ALU result
  localparam logic [1:0] FWD_W  = 2'd2;  // W-stage write data

  // Tags are stored at this fixed width so the record type does not depend
  // on the block parameter; narrower AW tags are zero-extended into it.
  localparam int unsigned REC_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic              we;
    logic [1:0]        cls;
  } stage_rec_t;

  // The instruction now in E will sit in M during the consumer's E cycle;
  // the one now in M will be in W. E is checked first (newest data wins).
  function automatic logic [1:0] fwd_sel(input logic       e_hit,
                                         input logic [1:0] e_cls,
                                         input logic       m_hit,
                                         input logic [1:0] m_cls);
    logic [1:0] sel;
    sel = FWD_RF;
    if (e_hit && (e_cls == CLS_ALU)) begin
      sel = FWD_M;
    end else if (m_hit && ((m_cls == CLS_ALU) || (m_cls == CLS_LOAD))) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage handshake, flush/muldiv control and
// scoreboard status bundle.
//   master: decode side -- drives d_*, flush, md_done; sees d_ready, stall,
//           md_busy, fwd_a, fwd_b, stall_cnt
//   slave : hazard_scoreboard -- the opposite directions
interface hazard_scoreboard_if #(
  parameter int AW   = 5,
  parameter int CNTW = 16
);
  logic            d_valid;
  logic [AW-1:0]   d_rs1;
  logic [AW-1:0]   d_rs2;
  logic            d_rs1_use;
  logic            d_rs2_use;
  logic [AW-1:0]   d_rd;
  logic            d_rd_we;
  logic [1:0]      d_cls;
  logic            d_ready;
  logic            stall;
  logic            flush;
  logic            md_done;
  logic            md_busy;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rs1_use, d_rs2_use, d_rd, d_rd_we, d_cls,
    output flush, md_done,
    input  d_ready, stall, md_busy, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rs1_use, d_rs2_use, d_rd, d_rd_we, d_cls,
    input  flush, md_done,
    output d_ready, stall, md_busy, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_tag_match.sv
// hazard_tag_match: one producer-record vs one decode-source comparison.
//   tag_i   decode source register
//   valid_i producer record valid
//   we_i    producer writes its rd
//   rd_i    producer destination
//   use_i   decode instruction actually reads tag_i
//   hit_o   source depends on this producer (r0 never creates a dependency)
module hazard_tag_match #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] tag_i,
  input  logic          valid_i,
  input  logic          we_i,
  input  logic [AW-1:0] rd_i,
  input  logic          use_i,
  output logic          hit_o
);

  assign hit_o = valid_i & we_i & use_i & (rd_i != {AW{1'b0}}) & (rd_i == tag_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use / muldiv interlock and registered E-stage
// bypass selection for the five-stage core.
//   clock     rising-edge clock
//   reset_n   synchronous active-low reset
//   bus       hazard_scoreboard_if.slave: decode handshake (d_*, d_ready,
//             stall), flush, md_done, md_busy, fwd_a/fwd_b, stall_cnt
// d_ready/stall are combinational from state and d_* only; everything else
// is registered.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  hazard_scoreboard_if.slave   bus
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  // Only E and M are kept: a producer in M at issue time is in W during the
  // consumer's E cycle, which is all the W bypass needs to know.
  stage_rec_t        e_q, e_d, m_q;
  logic              md_busy_q;
  logic [REC_AW-1:0] md_rd_q, md_rd_d;
  logic [1:0]        fwd_a_q, fwd_b_q;
  logic [CNTW-1:0]   stall_cnt_q;

  logic [REC_AW-1:0] rs1_s, rs2_s, rd_s;
  logic hit_e1_s, hit_e2_s, hit_m1_s, hit_m2_s, hit_md1_s, hit_md2_s;
  logic load_use_s, md_raw_s, md_waw_s, md_struct_s;
  logic d_ready_s, issue_s, is_md_s, rd_legal_s;

  assign rs1_s = REC_AW'(bus.d_rs1);
  assign rs2_s = REC_AW'(bus.d_rs2);
  assign rd_s  = REC_AW'(bus.d_rd);

  hazard_tag_match #(.AW(REC_AW)) u_e_rs1 (.tag_i(rs1_s), .valid_i(e_q.valid), .we_i(e_q.we),
    .rd_i(e_q.rd), .use_i(bus.d_rs1_use), .hit_o(hit_e1_s));
  hazard_tag_match #(.AW(REC_AW)) u_e_rs2 (.tag_i(rs2_s), .valid_i(e_q.valid), .we_i(e_q.we),
    .rd_i(e_q.rd), .use_i(bus.d_rs2_use), .hit_o(hit_e2_s));
  hazard_tag_match #(.AW(REC_AW)) u_m_rs1 (.tag_i(rs1_s), .valid_i(m_q.valid), .we_i(m_q.we),
    .rd_i(m_q.rd), .use_i(bus.d_rs1_use), .hit_o(hit_m1_s));
  hazard_tag_match #(.AW(REC_AW)) u_m_rs2 (.tag_i(rs2_s), .valid_i(m_q.valid), .we_i(m_q.we),
    .rd_i(m_q.rd), .use_i(bus.d_rs2_use), .hit_o(hit_m2_s));
  // md_rd is already 0 for a non-writing muldiv, so we is tied high here.
  hazard_tag_match #(.AW(REC_AW)) u_md_rs1 (.tag_i(rs1_s), .valid_i(md_busy_q), .we_i(1'b1),
    .rd_i(md_rd_q), .use_i(bus.d_rs1_use), .hit_o(hit_md1_s));
  hazard_tag_match #(.AW(REC_AW)) u_md_rs2 (.tag_i(rs2_s), .valid_i(md_busy_q), .we_i(1'b1),
    .rd_i(md_rd_q), .use_i(bus.d_rs2_use), .hit_o(hit_md2_s));

  // Interlock conditions, issue decision and next E record.
  always_comb begin
    is_md_s     = (bus.d_cls == CLS_MULDIV);
    rd_legal_s  = ({1'b0, bus.d_rd} < NREG_W);
    load_use_s  = (e_q.cls == CLS_LOAD) & (hit_e1_s | hit_e2_s);
    md_raw_s    = hit_md1_s | hit_md2_s;
    md_waw_s    = md_busy_q & bus.d_rd_we & (rd_s == md_rd_q);
    md_struct_s = md_busy_q & is_md_s;
    d_ready_s   = ~(load_use_s | md_raw_s | md_waw_s | md_struct_s);
    issue_s     = bus.d_valid & d_ready_s & ~bus.flush;

    md_rd_d = (bus.d_rd_we & rd_legal_s) ? rd_s : {REC_AW{1'b0}};

    e_d = '0;
    if (issue_s) begin
      e_d.valid = 1'b1;
      e_d.rd    = rd_s;
      // Muldiv results reach the regfile via md_done, never via the bypass.
      e_d.we    = bus.d_rd_we & rd_legal_s & ~is_md_s;
      e_d.cls   = bus.d_cls;
    end else begin
      e_d = '0;
    end
  end

  // Pipeline records, muldiv scoreboard, bypass selects and stall counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      e_q         <= '0;
      m_q         <= '0;
      md_busy_q   <= 1'b0;
      md_rd_q     <= {REC_AW{1'b0}};
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= {CNTW{1'b0}};
    end else begin
      m_q <= e_q;
      e_q <= e_d;
      fwd_a_q <= issue_s ? fwd_sel(hit_e1_s, e_q.cls, hit_m1_s, m_q.cls) : FWD_RF;
      fwd_b_q <= issue_s ? fwd_sel(hit_e2_s, e_q.cls, hit_m2_s, m_q.cls) : FWD_RF;
      // A new muldiv can only issue while idle, so it never races md_done.
      if (issue_s && is_md_s) begin
        md_busy_q <= 1'b1;
        md_rd_q   <= md_rd_d;
      end else if (bus.md_done) begin
        md_busy_q <= 1'b0;
        md_rd_q   <= {REC_AW{1'b0}};
      end else begin
        md_busy_q <= md_busy_q;
        md_rd_q   <= md_rd_q;
      end
      if (bus.stall && (stall_cnt_q != {CNTW{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign bus.d_ready   = d_ready_s;
  assign bus.stall     = bus.d_valid & ~d_ready_s;
  assign bus.md_busy   = md_busy_q;
  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a directed vector table, a few
// hand-written multi-cycle sequences and a random phase, all cross-checked
// against a rule-level reference model.
module tb_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int CNTW = 8;
  localparam int NREG = 32;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .CNTW(CNTW)) bus ();
  hazard_scoreboard #(.NREG(NREG), .AW(AW), .CNTW(CNTW)) dut (
    .clock(clk), .reset_n(rst_n), .bus(bus));

  typedef struct {
    bit rst; bit valid; int rs1; bit u1; int rs2; bit u2;
    int rd; bit we; int cls; bit flush; bit md_done;
  } in_t;
  typedef struct { in_t in; bit rdy; int fa; int fb; bit busy; int cnt; } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic act_rdy;

  // Reference model: index 0 = instruction in E, 1 = instruction in M.
  bit pv[2]; int prd[2]; bit pwe[2]; int pcls[2];
  bit mb; int mrd; int mcnt; int mfa; int mfb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic in_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, int cls);
    in_t s;
    s.rst = 1'b1; s.valid = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.we = we; s.cls = cls; s.flush = 1'b0; s.md_done = 1'b0;
    return s;
  endfunction

  function automatic vec_t mkv(in_t s, bit rdy, int fa, int fb, bit busy, int cnt);
    vec_t v;
    v.in = s; v.rdy = rdy; v.fa = fa; v.fb = fb; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  function automatic bit dep(int s, int src, bit u);
    return pv[s] && pwe[s] && (prd[s] != 0) && (prd[s] == src) && u;
  endfunction

  function automatic int mfwd(int src, bit u);
    if (dep(0, src, u) && pcls[0] == 0) return 1;
    if (dep(1, src, u) && (pcls[1] == 0 || pcls[1] == 1)) return 2;
    return 0;
  endfunction

  function automatic bit mready(in_t s);
    bit lu, raw, waw, st;
    lu  = (pcls[0] == 1) && pv[0] && (dep(0, s.rs1, s.u1) || dep(0, s.rs2, s.u2));
    raw = mb && (mrd != 0) && ((s.u1 && s.rs1 == mrd) || (s.u2 && s.rs2 == mrd));
    waw = mb && s.we && (s.rd == mrd);
    st  = mb && (s.cls == 2);
    return !(lu || raw || waw || st);
  endfunction

  task automatic model_clock(in_t s, bit rdy);
    bit issue;
    int na, nb;
    if (!s.rst) begin
      pv = '{0, 0}; pwe = '{0, 0}; prd = '{0, 0}; pcls = '{0, 0};
      mb = 0; mrd = 0; mcnt = 0; mfa = 0; mfb = 0;
      return;
    end
    issue = s.valid && rdy && !s.flush;
    if (s.valid && !rdy && mcnt < CMAX) mcnt++;
    na = issue ? mfwd(s.rs1, s.u1) : 0;
    nb = issue ? mfwd(s.rs2, s.u2) : 0;
    pv[1] = pv[0]; prd[1] = prd[0]; pwe[1] = pwe[0]; pcls[1] = pcls[0];
    pv[0] = issue; prd[0] = s.rd; pwe[0] = issue && s.we && (s.cls != 2); pcls[0] = s.cls;
    if (issue && s.cls == 2) begin
      mb = 1; mrd = s.we ? s.rd : 0;
    end else if (s.md_done) begin
      mb = 0; mrd = 0;
    end
    mfa = na; mfb = nb;
  endtask

  // One clock: drive at negedge, check combinational outputs, clock the
  // model at posedge and check registered outputs 1 time unit later.
  task automatic step(input in_t s);
    bit er;
    @(negedge clk);
    rst_n = s.rst;
    bus.d_valid = s.valid; bus.d_rs1 = AW'(s.rs1); bus.d_rs2 = AW'(s.rs2);
    bus.d_rs1_use = s.u1; bus.d_rs2_use = s.u2; bus.d_rd = AW'(s.rd);
    bus.d_rd_we = s.we; bus.d_cls = 2'(s.cls); bus.flush = s.flush; bus.md_done = s.md_done;
    #1;
    er = mready(s);
    act_rdy = bus.d_ready;
    chk("d_ready", bus.d_ready, er);
    chk("stall", bus.stall, s.valid && !er);
    @(posedge clk);
    model_clock(s, er);
    #1;
    chk("fwd_a", bus.fwd_a, mfa);
    chk("fwd_b", bus.fwd_b, mfb);
    chk("md_busy", bus.md_busy, mb);
    chk("stall_cnt", bus.stall_cnt, mcnt);
  endtask

  initial begin
    vec_t tbl[10];
    in_t s;

    rst_n = 1'b0;
    bus.d_valid = 1'b0; bus.d_rs1 = '0; bus.d_rs2 = '0; bus.d_rs1_use = 1'b0;
    bus.d_rs2_use = 1'b0; bus.d_rd = '0; bus.d_rd_we = 1'b0; bus.d_cls = 2'd0;
    bus.flush = 1'b0; bus.md_done = 1'b0;
    pv = '{0, 0}; pwe = '{0, 0}; prd = '{0, 0}; pcls = '{0, 0};
    mb = 0; mrd = 0; mcnt = 0; mfa = 0; mfb = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.d_ready, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.md_busy, 0);
    chk("rst_fwd_a", bus.fwd_a, 0);
    chk("rst_fwd_b", bus.fwd_b, 0);
    chk("rst_cnt", bus.stall_cnt, 0);

    // Directed table: ALU bypass, load-use, flush, r0.
    tbl[0] = mkv(mk(1, 1, 0, 2, 0, 3, 1, 0), 1, 0, 0, 0, 0);   // ALU r3
    tbl[1] = mkv(mk(1, 3, 1, 0, 0, 4, 1, 0), 1, 1, 0, 0, 0);   // reads r3 -> fwd_a=1
    tbl[2] = mkv(mk(1, 1, 1, 0, 0, 5, 1, 1), 1, 0, 0, 0, 0);   // LOAD r5
    tbl[3] = mkv(mk(1, 6, 1, 5, 1, 6, 1, 0), 0, 0, 0, 0, 1);   // load-use stall
    tbl[4] = mkv(mk(1, 6, 1, 5, 1, 6, 1, 0), 1, 0, 2, 0, 1);   // issues, fwd_b=2
    s = mk(1, 0, 0, 0, 0, 9, 1, 1); s.flush = 1'b1;
    tbl[5] = mkv(s, 1, 0, 0, 0, 1);                            // flushed LOAD r9
    tbl[6] = mkv(mk(1, 9, 1, 0, 0, 10, 1, 0), 1, 0, 0, 0, 1);  // r9 reader, no stall
    tbl[7] = mkv(mk(1, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 1);   // ALU r0
    tbl[8] = mkv(mk(1, 0, 1, 0, 1, 11, 1, 0), 1, 0, 0, 0, 1);  // reads r0
    tbl[9] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1);   // idle
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d_ready", i), act_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_fwd_a", i), bus.fwd_a, tbl[i].fa);
      chk($sformatf("tbl%0d_fwd_b", i), bus.fwd_b, tbl[i].fb);
      chk($sformatf("tbl%0d_busy", i), bus.md_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_cnt", i), bus.stall_cnt, tbl[i].cnt);
    end

    // MULDIV r7, dependent held 6 cycles, md_done in the 6th.
    step(mk(1, 0, 0, 0, 0, 7, 1, 2));
    chk("md_issue", act_rdy, 1);
    chk("md_busy_set", bus.md_busy, 1);
    for (int i = 1; i <= 6; i++) begin
      s = mk(1, 7, 1, 0, 0, 8, 1, 0); s.md_done = (i == 6);
      step(s);
      chk("md_dep_held", act_rdy, 0);
      chk("md_busy_hold", bus.md_busy, (i < 6) ? 1 : 0);
    end
    step(mk(1, 7, 1, 0, 0, 8, 1, 0));
    chk("md_dep_issue", act_rdy, 1);
    chk("md_dep_fwd", bus.fwd_a, 0);
    chk("md_dep_cnt", bus.stall_cnt, 7);

    // Second MULDIV while busy: stalls through md_done, issues the cycle after.
    step(mk(1, 0, 0, 0, 0, 11, 1, 2));
    for (int i = 1; i <= 3; i++) begin
      s = mk(1, 0, 0, 0, 0, 12, 1, 2); s.md_done = (i == 3);
      step(s);
      chk("md2_held", act_rdy, 0);
    end
    step(mk(1, 0, 0, 0, 0, 12, 1, 2));
    chk("md2_issue", act_rdy, 1);
    chk("md2_busy", bus.md_busy, 1);
    s = mk(0, 0, 0, 0, 0, 0, 0, 0); s.md_done = 1'b1;
    step(s);
    chk("md2_clear", bus.md_busy, 0);

    // Reset mid-muldiv with a stalled dependent; reset beats md_done/flush.
    step(mk(1, 0, 0, 0, 0, 13, 1, 2));
    step(mk(1, 13, 1, 0, 0, 14, 1, 0));
    step(mk(1, 13, 1, 0, 0, 14, 1, 0));
    chk("rstmd_stalled", act_rdy, 0);
    s = mk(1, 13, 1, 0, 0, 14, 1, 0); s.rst = 1'b0; s.md_done = 1'b1; s.flush = 1'b1;
    step(s);
    chk("rstmd_busy", bus.md_busy, 0);
    chk("rstmd_fwd_a", bus.fwd_a, 0);
    chk("rstmd_cnt", bus.stall_cnt, 0);
    step(mk(1, 13, 1, 0, 0, 14, 1, 0));
    chk("rstmd_ready", act_rdy, 1);

    // Saturation of the stall counter.
    step(mk(1, 0, 0, 0, 0, 14, 1, 2));
    for (int i = 0; i < (1 << CNTW) + 3; i++) step(mk(1, 0, 0, 0, 0, 15, 1, 2));
    chk("sat_cnt", bus.stall_cnt, CMAX);
    chk("sat_stall", act_rdy, 0);
    s = mk(0, 0, 0, 0, 0, 0, 0, 0); s.rst = 1'b0;
    step(s);

    // Random phase against the model.
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      s.flush   = ($urandom_range(0, 15) == 0);
      s.md_done = mb && ($urandom_range(0, 3) == 0);
      s.rst     = ($urandom_range(0, 199) != 0);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Sequential hazard and bypass controller that replaces the combinational load-use/bypass logic of the five-stage core. It tracks destination tags for the E, M and W stages, plus one outstanding multi-cycle multiply/divide. From these it produces the decode-stage issue handshake and registered bypass selects for the E stage. The register count is parametrised, and the block adds muldiv scoreboarding, flush handling and a stall performance counter.

## Interface
- NREG, 32, architectural register count; register 0 is hard-wired zero
- AW, 5, register address width; must equal clog2(NREG)
- CNTW, 16, stall counter width
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- d_valid  in  1  decode stage holds an instruction
- d_rs1, d_rs2  in  AW  decode source registers
- d_rs1_use, d_rs2_use  in  1  source is actually read
- d_rd  in  AW  decode destination register
- d_rd_we  in  1  instruction writes d_rd
- d_cls  in  2  class: 0 ALU, 1 LOAD, 2 MULDIV, 3 OTHER (non-writing, e.g. store or branch)
- d_ready  out  1  instruction issues when d_valid & d_ready
- stall  out  1  d_valid & ~d_ready
- flush  in  1  squash the issuing instruction and the E-stage record
- md_done  in  1  muldiv unit writes its result to the regfile this cycle
- md_busy  out  1  a muldiv is outstanding
- fwd_a, fwd_b  out  2  E-stage operand select: 0 regfile, 1 M-stage ALU result, 2 W-stage data
- stall_cnt  out  CNTW  count of stall cycles, saturating

## Operation
- Each stage record holds {valid, rd, we, cls} for E, M and W. Every cycle W<=M and M<=E. E<=the issuing record, or a bubble when there is no issue or flush=1.
- "Match(x)" means: the record is valid, we=1, rd!=0, rd==x, and x is used by the decode instruction.
- d_ready=0 when any of these holds:
  - Load-use: the E record has cls LOAD and matches rs1 or rs2.
  - Muldiv RAW: md_busy=1, md_rd!=0 and md_rd equals a used source.
  - Muldiv WAW: md_busy=1, d_rd_we=1 and d_rd==md_rd.
  - Structural: md_busy=1 and d_cls=MULDIV.
- On a MULDIV issue: md_busy<=1 and md_rd<=d_rd (md_rd is 0 if we=0). The E record gets we=0, so there is no pipeline bypass for muldiv.
- md_busy clears on the clock edge of md_done. Dependents stay stalled in the md_done cycle and issue the following cycle, reading the regfile.
- Bypass selection on issue, evaluated per source:
  - Match against E with cls ALU gives fwd=1.
  - Otherwise, match against M with cls ALU or LOAD gives fwd=2.
  - Otherwise fwd=0.
  - E-record precedence is newest-first.
- On a bubble or flush, fwd_a and fwd_b are registered to 0.
- flush does not cancel an outstanding muldiv. M and W records retire normally under flush.
- stall_cnt increments when stall=1 and holds at all-ones.
- reset_n=0 sets, at the next edge: all records invalid, md_busy=0, md_rd=0, fwd_a=fwd_b=0, stall_cnt=0. Combinationally this gives d_ready=1 and stall=0 after reset. Reset overrides md_done and flush in the same cycle.

## Timing
- d_ready and stall are combinational from state and d_* inputs. There is no combinational path from flush or md_done to d_ready.
- fwd_a and fwd_b are registered: the value is computed in the issue cycle t and valid throughout the E cycle t+1.
- Load-use costs exactly 1 stall cycle. The consumer then issues with fwd=2.
- The muldiv dependent issues at the cycle after md_done.
- If md_done and a new MULDIV decode coincide, the new MULDIV stalls that cycle and issues the next.

## Structure
- Shared package hazard_pkg holds:
  - the class encodings CLS_ALU, CLS_LOAD, CLS_MULDIV, CLS_OTHER
  - the select encodings FWD_RF, FWD_M, FWD_W
  - the stage record typedef
- Sub-module hazard_tag_match(tag, valid, we, rd, use -> hit): a single AW-bit equality that qualifies rd!=0. It is instantiated once per (stage, source) pair.

## Test plan
- ALU r3 issued, then ALU reading r3 the next cycle -> no stall; fwd_a=1 during the consumer's E cycle.
- LOAD r5, then ADD using r5 as rs2 -> stall=1 for 1 cycle, stall_cnt=1; consumer issues with fwd_b=2.
- MULDIV r7, then a reader of r7; assert md_done 6 cycles later -> stall held for 6 cycles, issue at cycle 7 with fwd=0, md_busy falls after md_done.
- Source r0 with an ALU r0 producer in E -> no stall, fwd=0. A second MULDIV while busy -> stall until md_done+1.
- flush in the cycle a LOAD r9 issues, followed by a r9 reader -> no stall, fwd=0.
- Reset mid-muldiv with stall active -> md_busy=0, stall=0, stall_cnt=0, fwd=0 at the next cycle. Force stall for 2^CNTW+3 cycles -> stall_cnt saturates at all-ones.
